// File: rtl/motor_commander_pkg.sv
// Shared types and constants for motor_commander: FSM states, command word
// layout, report tag values and small helpers used by the top level.
package motor_commander_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [3:0] TAG_OVF = 4'hF;
    localparam logic [3:0] TAG_MAX = 4'd14;

    localparam int PWM_W        = 11;
    localparam int CMD_PWM1_LSB = 0;
    localparam int CMD_DIR0_BIT = 11;
    localparam int CMD_PWM2_LSB = 12;
    localparam int CMD_DIR1_BIT = 23;

    function automatic logic [3:0] tag_next(input logic [3:0] t);
        return (t == TAG_MAX) ? 4'd0 : t + 4'd1;
    endfunction

    function automatic logic [23:0] pack_cmd(input logic [1:0] dir,
                                             input logic [PWM_W-1:0] pwm1,
                                             input logic [PWM_W-1:0] pwm2);
        logic [23:0] w;
        w = '0;
        w[CMD_PWM1_LSB +: PWM_W] = pwm1;
        w[CMD_DIR0_BIT]          = dir[0];
        w[CMD_PWM2_LSB +: PWM_W] = pwm2;
        w[CMD_DIR1_BIT]          = dir[1];
        return w;
    endfunction

    // Next ramp value: one step above the current PWM, never beyond the target.
    function automatic logic [PWM_W-1:0] ramp_next(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt,
                                                   input logic [PWM_W-1:0] step);
        logic [PWM_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum >= {1'b0, tgt}) ? tgt : sum[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/motor_commander_odo.sv
// motor_odo_acc: one wheel's odometer, a 12-bit report count added into a
// 16-bit saturating accumulator, plus the "distance reached" compare.
module motor_odo_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        add_en_i,
    input  logic [11:0] add_val_i,
    input  logic [15:0] target_i,
    output logic [15:0] odo_o,
    output logic        complete_o
);

    logic [15:0] odo_q, odo_d;
    logic [16:0] sum;

    always_comb begin
        sum   = {1'b0, odo_q} + {5'd0, add_val_i};
        odo_d = odo_q;
        if (clr_i) begin
            odo_d = '0;
        end else if (add_en_i) begin
            odo_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odo_q <= '0;
        end else begin
            odo_q <= odo_d;
        end
    end

    assign odo_o      = odo_q;
    assign complete_o = (odo_q >= target_i);

endmodule

// File: rtl/motor_commander.sv
// motor_commander: issues rolling-tag PWM commands, accumulates tagged odometry
// reports and stops once both wheels reach distance. Ramp: MOTOR_COMMANDER_RAMP_EN.
module motor_commander
    import motor_commander_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 100000,
    parameter int unsigned RAMP_STEP   = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mv_valid,
    output logic        mv_ready,
    input  logic [1:0]  mv_dir,
    input  logic [10:0] mv_pwm1,
    input  logic [10:0] mv_pwm2,
    input  logic [15:0] mv_dist1,
    input  logic [15:0] mv_dist2,
    input  logic        abort,
    output logic [3:0]  cmd_ctrl,
    output logic [23:0] cmd_data,
    output logic        cmd_wr,
    input  logic [3:0]  rpt_ctrl,
    input  logic [23:0] rpt_data,
    input  logic        rpt_wr,
    output logic        busy,
    output logic        done,
    output logic [15:0] odo1,
    output logic [15:0] odo2,
    output logic        tag_err,
    output logic        ovf_err,
    output logic [2:0]  dbg_state
);

    localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] POLL_LOAD = TW'(POLL_CYCLES - 1);
    localparam logic [10:0] STEP = 11'(RAMP_STEP);
`ifdef MOTOR_COMMANDER_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    state_e        state_q;
    logic [1:0]    dir_q;
    logic [10:0]   tgt1_q, tgt2_q, eff1_q, eff2_q;
    logic [15:0]   dist1_q, dist2_q;
    logic [3:0]    tag_q, cmd_ctrl_q;
    logic [23:0]   cmd_data_q;
    logic          cmd_wr_q, done_q, busy_q, tag_err_q, ovf_err_q, rpt_pend_q;
    logic [TW-1:0] timer_q;

    logic          rpt_take, rpt_ok, rpt_ovf, rpt_bad, acc_clr, cmp1, cmp2;
    logic [10:0]   eff1_d, eff2_d, pwm1_d, pwm2_d;

    // Report fields are valid the cycle after rpt_wr; cmd_ctrl_q is the last issued tag,
    // so a report landing on an issue cycle is matched before the tag moves on.
    always_comb begin
        rpt_take = rpt_pend_q && (state_q != S_IDLE);
        rpt_ovf  = rpt_take && (rpt_ctrl == TAG_OVF);
        rpt_ok   = rpt_take && (rpt_ctrl == cmd_ctrl_q);
        rpt_bad  = rpt_take && !rpt_ovf && !rpt_ok;
        acc_clr  = (state_q == S_IDLE) && mv_valid;
        eff1_d   = RAMP_ON ? ramp_next(eff1_q, tgt1_q, STEP) : tgt1_q;
        eff2_d   = RAMP_ON ? ramp_next(eff2_q, tgt2_q, STEP) : tgt2_q;
        pwm1_d   = cmp1 ? 11'd0 : eff1_d;
        pwm2_d   = cmp2 ? 11'd0 : eff2_d;
    end

    motor_odo_acc u_acc1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (acc_clr),
        .add_en_i   (rpt_ok),
        .add_val_i  (rpt_data[11:0]),
        .target_i   (dist1_q),
        .odo_o      (odo1),
        .complete_o (cmp1)
    );

    motor_odo_acc u_acc2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (acc_clr),
        .add_en_i   (rpt_ok),
        .add_val_i  (rpt_data[23:12]),
        .target_i   (dist2_q),
        .odo_o      (odo2),
        .complete_o (cmp2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dir_q      <= '0;
            tgt1_q     <= '0;
            tgt2_q     <= '0;
            eff1_q     <= '0;
            eff2_q     <= '0;
            dist1_q    <= '0;
            dist2_q    <= '0;
            tag_q      <= '0;
            cmd_ctrl_q <= '0;
            cmd_data_q <= '0;
            cmd_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            tag_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
            rpt_pend_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            cmd_wr_q   <= 1'b0;
            done_q     <= 1'b0;
            rpt_pend_q <= rpt_wr;
            if (rpt_bad) tag_err_q <= 1'b1;
            if (rpt_ovf) ovf_err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (mv_valid) begin
                        dir_q     <= mv_dir;
                        tgt1_q    <= mv_pwm1;
                        tgt2_q    <= mv_pwm2;
                        dist1_q   <= mv_dist1;
                        dist2_q   <= mv_dist2;
                        eff1_q    <= '0;
                        eff2_q    <= '0;
                        tag_err_q <= 1'b0;
                        ovf_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_wr_q   <= 1'b1;
                    cmd_ctrl_q <= tag_q;
                    cmd_data_q <= pack_cmd(dir_q, pwm1_d, pwm2_d);
                    tag_q      <= tag_next(tag_q);
                    eff1_q     <= eff1_d;
                    eff2_q     <= eff2_d;
                    timer_q    <= POLL_LOAD;
                    state_q    <= S_RUN;
                end
                S_RUN: begin
                    if (abort || (cmp1 && cmp2)) begin
                        state_q <= S_STOP;
                    end else if (timer_q == '0) begin
                        state_q <= S_ISSUE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                S_STOP: begin
                    cmd_wr_q   <= 1'b1;
                    cmd_ctrl_q <= tag_q;
                    cmd_data_q <= pack_cmd(dir_q, 11'd0, 11'd0);
                    tag_q      <= tag_next(tag_q);
                    state_q    <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (rpt_ok) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mv_ready  = !busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ctrl  = cmd_ctrl_q;
    assign cmd_data  = cmd_data_q;
    assign cmd_wr    = cmd_wr_q;
    assign tag_err   = tag_err_q;
    assign ovf_err   = ovf_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_commander.sv
// Bench for motor_commander: motor model answering each command, reference
// model of the whole move, and scoreboards on commands and done pulses.
module tb_motor_commander;

  localparam int POLL      = 40;
  localparam int RAMP_STEP = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv_valid, mv_ready;
  logic [1:0]  mv_dir;
  logic [10:0] mv_pwm1, mv_pwm2;
  logic [15:0] mv_dist1, mv_dist2;
  logic        abort;
  logic [3:0]  cmd_ctrl;
  logic [23:0] cmd_data;
  logic        cmd_wr;
  logic [3:0]  rpt_ctrl;
  logic [23:0] rpt_data;
  logic        rpt_wr;
  logic        busy, done, tag_err, ovf_err;
  logic [15:0] odo1, odo2;
  logic [2:0]  dbg_state;

  motor_commander #(.POLL_CYCLES(POLL), .RAMP_STEP(RAMP_STEP)) dut (
    .clk(clk), .rst_n(rst_n), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_dir(mv_dir), .mv_pwm1(mv_pwm1), .mv_pwm2(mv_pwm2),
    .mv_dist1(mv_dist1), .mv_dist2(mv_dist2), .abort(abort),
    .cmd_ctrl(cmd_ctrl), .cmd_data(cmd_data), .cmd_wr(cmd_wr),
    .rpt_ctrl(rpt_ctrl), .rpt_data(rpt_data), .rpt_wr(rpt_wr),
    .busy(busy), .done(done), .odo1(odo1), .odo2(odo2),
    .tag_err(tag_err), .ovf_err(ovf_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  logic [27:0] exp_cmd_q[$];   // {tag, cmd_data}
  logic [35:0] exp_done_q[$];  // {odo1, odo2, tag_err, ovf_err, busy, mv_ready}
  logic [27:0] inj_q[$];       // extra reports {tag, data}
  logic [3:0]  exp_tag = 4'd0;
  logic [11:0] model_c1 = 12'd0;
  logic [11:0] model_c2 = 12'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_pwm(input logic [10:0] tgt, input int k);
`ifdef MOTOR_COMMANDER_RAMP_EN
    int v;
    v = (k + 1) * RAMP_STEP;
    return (v > int'(tgt)) ? tgt : 11'(v);
`else
    return (k >= 0) ? tgt : 11'd0;
`endif
  endfunction

  // motor model: answers each command after a short latency with counts per wheel
  initial begin : motor_model
    int cd, hold;
    bit m_pend;
    logic [3:0] m_tag;
    logic [23:0] m_data;
    logic [27:0] inj;
    rpt_wr = 1'b0; rpt_ctrl = 4'd0; rpt_data = 24'd0;
    cd = 0; hold = 0; m_pend = 1'b0; m_tag = 4'd0; m_data = 24'd0;
    forever begin
      @(negedge clk);
      rpt_wr = 1'b0;
      if (!rst_n) begin
        cd = 0; hold = 0; m_pend = 1'b0;
        inj_q.delete();
      end else begin
        if (m_pend && cd > 0) cd--;
        if (hold > 0) hold--;
        else if (m_pend && cd == 0) begin
          rpt_wr = 1'b1; rpt_ctrl = m_tag; rpt_data = m_data;
          m_pend = 1'b0; hold = 2;
        end else if (!m_pend && inj_q.size() > 0) begin
          inj = inj_q.pop_front();
          rpt_wr = 1'b1; {rpt_ctrl, rpt_data} = inj;
          hold = 2;
        end
        if (cmd_wr) begin
          m_tag  = cmd_ctrl;
          m_data = {(cmd_data[22:12] != 11'd0) ? model_c2 : 12'd0,
                    (cmd_data[10:0]  != 11'd0) ? model_c1 : 12'd0};
          cd = $urandom_range(5, 2);
          m_pend = 1'b1;
        end
      end
    end
  end

  // scoreboard: commands
  initial begin : cmd_mon
    forever begin
      @(negedge clk);
      if (rst_n && cmd_wr) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd_unexpected: actual=%0h required=none", {cmd_ctrl, cmd_data});
        end else begin
          check("cmd_word", {cmd_ctrl, cmd_data}, exp_cmd_q.pop_front());
        end
      end
    end
  end

  // scoreboard: move completion
  initial begin : done_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (prev) check("done_pulse_width", done, 1'b0);
      if (rst_n && done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: actual=1 required=0");
        end else begin
          check("done_result", {odo1, odo2, tag_err, ovf_err, busy, mv_ready},
                exp_done_q.pop_front());
        end
      end
      prev = done;
    end
  end

  task automatic check_reset_outputs();
    check("rst_cmd_wr",   cmd_wr, 1'b0);
    check("rst_cmd_ctrl", cmd_ctrl, 4'd0);
    check("rst_cmd_data", cmd_data, 24'd0);
    check("rst_busy_rdy", {busy, mv_ready, done}, 3'b010);
    check("rst_odo",      {odo1, odo2}, 32'd0);
    check("rst_errs",     {tag_err, ovf_err}, 2'b00);
  endtask

  // reference model of a whole move, then drive the request
  task automatic start_move(input logic [1:0] dir, input logic [10:0] p1, input logic [10:0] p2,
                            input logic [15:0] d1, input logic [15:0] d2,
                            input logic [11:0] c1, input logic [11:0] c2,
                            input bit do_abort, input bit do_inj, output int limit);
    int n1, n2, nn, o1, o2;
    logic [10:0] w1, w2;
    n1 = (d1 == 16'd0) ? 0 : (int'(d1) + int'(c1) - 1) / int'(c1);
    n2 = (d2 == 16'd0) ? 0 : (int'(d2) + int'(c2) - 1) / int'(c2);
    nn = (n1 > n2) ? n1 : n2;
    if (nn < 1) nn = 1;
    if (do_abort) nn = 1;
    for (int k = 0; k < nn; k++) begin
      w1 = (k < n1) ? exp_pwm(p1, k) : 11'd0;
      w2 = (k < n2) ? exp_pwm(p2, k) : 11'd0;
      exp_cmd_q.push_back({exp_tag, dir[1], w2, dir[0], w1});
      exp_tag = (exp_tag == 4'd14) ? 4'd0 : exp_tag + 4'd1;
    end
    exp_cmd_q.push_back({exp_tag, dir[1], 11'd0, dir[0], 11'd0});
    exp_tag = (exp_tag == 4'd14) ? 4'd0 : exp_tag + 4'd1;
    o1 = ((nn < n1) ? nn : n1) * int'(c1);
    o2 = ((nn < n2) ? nn : n2) * int'(c2);
    if (o1 > 65535) o1 = 65535;
    if (o2 > 65535) o2 = 65535;
    exp_done_q.push_back({16'(o1), 16'(o2), do_inj, do_inj, 1'b0, 1'b1});
    limit = (nn + 3) * (POLL + 2) + 50;
    model_c1 = c1; model_c2 = c2;
    mv_dir = dir; mv_pwm1 = p1; mv_pwm2 = p2; mv_dist1 = d1; mv_dist2 = d2;
    mv_valid = 1'b1;
    check("ready_in_idle", {mv_ready, busy}, 2'b10);
    @(negedge clk);
    mv_valid = 1'b0;
    check("busy_after_accept", {busy, mv_ready}, 2'b10);
  endtask

  task automatic finish_move(input int limit);
    int start;
    start = done_cnt;
    for (int i = 0; i < limit && done_cnt == start; i++) @(negedge clk);
    if (done_cnt == start) begin
      n_cmp++; n_bad++;
      $display("FAIL move_timeout: actual=no done required=done within %0d cycles", limit);
      exp_cmd_q.delete();
      exp_done_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_move(input logic [1:0] dir, input logic [10:0] p1, input logic [10:0] p2,
                          input logic [15:0] d1, input logic [15:0] d2,
                          input logic [11:0] c1, input logic [11:0] c2,
                          input bit do_abort, input bit do_inj);
    int limit;
    start_move(dir, p1, p2, d1, d2, c1, c2, do_abort, do_inj, limit);
    if (do_abort || do_inj) begin
      for (int i = 0; i < 10 && !cmd_wr; i++) @(negedge clk);
      check("first_cmd_seen", cmd_wr, 1'b1);
      if (do_inj) begin
        inj_q.push_back({4'd3, 24'h04D04D});
        inj_q.push_back({4'hF, 24'h04D04D});
      end
      if (do_abort) begin
        repeat (10) @(negedge clk);
        abort = 1'b1;
      end
    end
    finish_move(limit);
    abort = 1'b0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int limit;
    rst_n = 1'b0; mv_valid = 1'b0; mv_dir = 2'd0; mv_pwm1 = 11'd0; mv_pwm2 = 11'd0;
    mv_dist1 = 16'd0; mv_dist2 = 16'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    run_move(2'b01, 11'd1000, 11'd1000, 16'd100, 16'd100, 12'd30, 12'd30, 1'b0, 1'b0);
    run_move(2'b10, 11'd500, 11'd700, 16'd200, 16'd200, 12'd50, 12'd50, 1'b0, 1'b1);
    run_move(2'b11, 11'd800, 11'd900, 16'd0, 16'd50, 12'd20, 12'd20, 1'b0, 1'b0);
    run_move(2'b00, 11'd300, 11'd300, 16'd100, 16'd100, 12'd30, 12'd30, 1'b0, 1'b0);
    run_move(2'b01, 11'd500, 11'd500, 16'd1000, 16'd1000, 12'd100, 12'd100, 1'b1, 1'b0);

    abort = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_idle_busy", {busy, mv_ready}, 2'b01);
    abort = 1'b0;

    run_move(2'b10, 11'd2047, 11'd2047, 16'hFFFF, 16'hFFFF, 12'd4095, 12'd4095, 1'b0, 1'b0);

    for (int m = 0; m < 6; m++) begin
      logic [15:0] d1, d2;
      d1 = 16'($urandom_range(3000, 0));
      d2 = 16'($urandom_range(3000, 0));
      if (d1 == 16'd0 && d2 == 16'd0) d2 = 16'd1;
      run_move(2'($urandom_range(3, 0)), 11'($urandom_range(2047, 1)), 11'($urandom_range(2047, 1)),
               d1, d2, 12'($urandom_range(1000, 100)), 12'($urandom_range(1000, 100)), 1'b0, 1'b0);
    end

    start_move(2'b11, 11'd1500, 11'd1500, 16'd2000, 16'd2000, 12'd100, 12'd100, 1'b0, 1'b0, limit);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_cmd_q.delete();
    exp_done_q.delete();
    exp_tag = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_move(2'b01, 11'd600, 11'd400, 16'd90, 16'd150, 12'd45, 12'd75, 1'b0, 1'b0);

    for (int m = 0; m < 5; m++) begin
      logic [15:0] d1, d2;
      d1 = 16'($urandom_range(2500, 0));
      d2 = 16'($urandom_range(2500, 0));
      if (d1 == 16'd0 && d2 == 16'd0) d1 = 16'd1;
      run_move(2'($urandom_range(3, 0)), 11'($urandom_range(2047, 1)), 11'($urandom_range(2047, 1)),
               d1, d2, 12'($urandom_range(1000, 100)), 12'($urandom_range(1000, 100)), 1'b0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
